// File: rtl/vram_arb_pkg.sv
// VRAM arbiter shared definitions.
// Grant, CPU FSM and fill FSM encodings plus width defaults.
package vram_arb_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_FILL = 2'd3
  } gnt_e;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_ACK  = 1'b1
  } cpu_st_e;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_RUN  = 1'b1
  } fill_st_e;

endpackage

// File: rtl/vram_fill_engine.sv
// Linear fill engine: latches base/len/color and emits one write
// per fill grant, wrapping the address at 2^ADDR_W.
module vram_fill_engine
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] color,
  input  logic              gnt,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  fill_st_e          st, st_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic [DATA_W-1:0] color_q;
  logic              done_q;
  logic              last;

  assign last = (rem_q == ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) st <= F_IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      F_IDLE: if (start && len != '0) st_nx = F_RUN;
      F_RUN:  if (gnt && last)        st_nx = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (st == F_IDLE) begin
        if (start) begin
          addr_q  <= base;
          rem_q   <= len;
          color_q <= color;
          // zero-length fill completes without ever running
          done_q  <= (len == '0);
        end
      end else if (gnt) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - ADDR_W'(1);
        done_q <= last;
      end
    end
  end

  assign req   = (st == F_RUN);
  assign busy  = (st == F_RUN);
  assign addr  = addr_q;
  assign wdata = color_q;
  assign done  = done_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA has absolute priority, CPU and
// fill engine share remaining cycles round-robin.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_rdn,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_din,
  input  logic [DATA_W-1:0] vram_dout
);

  gnt_e              gnt;
  cpu_st_e           cst, cst_nx;
  logic              rr_cpu;
  logic              cpu_el;
  logic              cpu_rd_q;
  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_wdata;
  logic [DATA_W-1:0] vga_hold;
  logic [DATA_W-1:0] cpu_hold;

  vram_fill_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fill (
    .clk   (clk),
    .rst   (rst),
    .start (fill_start),
    .base  (fill_base),
    .len   (fill_len),
    .color (fill_color),
    .gnt   (gnt == GNT_FILL),
    .req   (fill_req),
    .addr  (fill_addr),
    .wdata (fill_wdata),
    .busy  (fill_busy),
    .done  (fill_done)
  );

  assign cpu_el = cpu_req && (cst == C_IDLE);

  always_comb begin
    gnt = GNT_NONE;
    if (rst)                  gnt = GNT_NONE;
    else if (!vga_rdn)        gnt = GNT_VGA;
    else if (cpu_el && fill_req)
      gnt = rr_cpu ? GNT_CPU : GNT_FILL;
    else if (cpu_el)          gnt = GNT_CPU;
    else if (fill_req)        gnt = GNT_FILL;
  end

  always_comb begin
    vram_addr = '0;
    vram_we   = 1'b0;
    vram_din  = '0;
    unique case (gnt)
      GNT_NONE: ;
      GNT_VGA:  vram_addr = vga_addr;
      GNT_CPU: begin
        vram_addr = cpu_addr;
        vram_we   = cpu_we;
        vram_din  = cpu_we ? cpu_wdata : '0;
      end
      GNT_FILL: begin
        vram_addr = fill_addr;
        vram_we   = 1'b1;
        vram_din  = fill_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cst <= C_IDLE;
    else     cst <= cst_nx;
  end

  // C_ACK blocks re-grant of a still-held cpu_req
  always_comb begin
    cst_nx = cst;
    unique case (cst)
      C_IDLE: if (gnt == GNT_CPU) cst_nx = C_ACK;
      C_ACK:  cst_nx = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_cpu    <= 1'b1;
      vga_valid <= 1'b0;
      vga_hold  <= '0;
      cpu_rd_q  <= 1'b0;
      cpu_hold  <= '0;
    end else begin
      vga_valid <= (gnt == GNT_VGA);
      cpu_rd_q  <= (gnt == GNT_CPU) && !cpu_we;
      if (vga_valid)            vga_hold <= vram_dout;
      if (cpu_ack && cpu_rd_q)  cpu_hold <= vram_dout;
      if (gnt == GNT_CPU)       rr_cpu   <= 1'b0;
      else if (gnt == GNT_FILL) rr_cpu   <= 1'b1;
    end
  end

  assign cpu_ack   = (cst == C_ACK);
  assign vga_data  = vga_valid ? vram_dout : vga_hold;
  assign cpu_rdata = (cpu_ack && cpu_rd_q) ? vram_dout : cpu_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM behavioural memory plus a
// transaction-level reference model checked every cycle.
module tb_vram_arbiter;

  localparam int AW = 19;
  localparam int DW = 12;

  logic          clk;
  logic          rst;
  logic          vga_rdn;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW-1:0] fill_len;
  logic [DW-1:0] fill_color;
  logic          fill_busy;
  logic          fill_done;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [DW-1:0] vram_din;
  logic [DW-1:0] vram_dout;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_rdn    (vga_rdn),
    .vga_addr   (vga_addr),
    .vga_data   (vga_data),
    .vga_valid  (vga_valid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_din   (vram_din),
    .vram_dout  (vram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM: synchronous, 1-cycle read latency, read-old-data
  logic [DW-1:0] mem [int];
  always @(posedge clk) begin
    vram_dout <= mem.exists(int'(vram_addr)) ? mem[int'(vram_addr)] : '0;
    if (vram_we) mem[int'(vram_addr)] = vram_din;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [DW-1:0] ref_mem [int];
  logic          m_cack, m_vv, m_rr, m_fdone;
  logic [DW-1:0] m_crd, m_vd, m_fcol;
  logic [AW-1:0] m_faddr, m_frem;

  int n_we, n_done, n_ack, n_busy, n_vv;
  logic [AW-1:0] wq [$];

  function automatic logic [DW-1:0] rdref(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  task automatic model_reset();
    m_cack  = 1'b0;
    m_vv    = 1'b0;
    m_rr    = 1'b1;
    m_fdone = 1'b0;
    m_crd   = '0;
    m_vd    = '0;
    m_frem  = '0;
    m_faddr = '0;
    m_fcol  = '0;
  endtask

  // one clock: check at negedge, advance model, return at posedge+1
  task automatic cycle();
    int            g;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ed;
    logic          c_el, f_el, idle, n_fdone;
    @(negedge clk);
    if (rst) begin
      chk("rst_we", 32'(vram_we), 32'd0);
      model_reset();
    end else begin
      chk("cpu_ack", 32'(cpu_ack), 32'(m_cack));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_crd));
      chk("vga_valid", 32'(vga_valid), 32'(m_vv));
      chk("vga_data", 32'(vga_data), 32'(m_vd));
      chk("fill_busy", 32'(fill_busy), 32'(m_frem != 0));
      chk("fill_done", 32'(fill_done), 32'(m_fdone));
      c_el = cpu_req && !m_cack;
      f_el = (m_frem != 0);
      if (!vga_rdn)          g = 1;
      else if (c_el && f_el) g = m_rr ? 2 : 3;
      else if (c_el)         g = 2;
      else if (f_el)         g = 3;
      else                   g = 0;
      ea = '0; ewe = 1'b0; ed = '0;
      if (g == 1) ea = vga_addr;
      if (g == 2) begin ea = cpu_addr; ewe = cpu_we; ed = cpu_wdata; end
      if (g == 3) begin ea = m_faddr; ewe = 1'b1; ed = m_fcol; end
      chk("vram_addr", 32'(vram_addr), 32'(ea));
      chk("vram_we", 32'(vram_we), 32'(ewe));
      if (ewe || g == 0) chk("vram_din", 32'(vram_din), 32'(ed));
      idle = (m_frem == 0);
      n_fdone = 1'b0;
      m_vv = (g == 1);
      if (g == 1) m_vd = rdref(vga_addr);
      if (g == 2) begin
        if (cpu_we) ref_mem[int'(cpu_addr)] = cpu_wdata;
        else        m_crd = rdref(cpu_addr);
        m_rr = 1'b0;
      end
      if (g == 3) begin
        ref_mem[int'(m_faddr)] = m_fcol;
        m_faddr = m_faddr + 1'b1;
        m_frem  = m_frem - 1'b1;
        if (m_frem == 0) n_fdone = 1'b1;
        m_rr = 1'b1;
      end
      if (idle && fill_start) begin
        if (fill_len == 0) n_fdone = 1'b1;
        else begin
          m_faddr = fill_base;
          m_frem  = fill_len;
          m_fcol  = fill_color;
        end
      end
      m_cack  = (g == 2);
      m_fdone = n_fdone;
      if (vram_we)   begin n_we++; wq.push_back(vram_addr); end
      if (fill_done) n_done++;
      if (cpu_ack)   n_ack++;
      if (fill_busy) n_busy++;
      if (vga_valid) n_vv++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    vga_rdn    = 1'b1;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    fill_start = 1'b0;
  endtask

  int we0, dn0, ak0, bz0, vv0;

  task automatic snap();
    we0 = n_we; dn0 = n_done; ak0 = n_ack; bz0 = n_busy; vv0 = n_vv;
    wq.delete();
  endtask

  initial begin
    model_reset();
    n_we = 0; n_done = 0; n_ack = 0; n_busy = 0; n_vv = 0;
    idle_in();
    rst = 1'b1;
    vga_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    fill_base = '0; fill_len = '0; fill_color = '0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("rst_vga_valid", 32'(vga_valid), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);

    // CPU write then read back
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 19'h00010; cpu_wdata = 12'hABC;
    cycle();
    cpu_req = 1'b0;
    cycle();
    cpu_req = 1'b1; cpu_we = 1'b0;
    cycle();
    cpu_req = 1'b0;
    cycle();
    chk("rd_abc", 32'(cpu_rdata), 32'hABC);

    // VGA blocks CPU for 5 cycles
    snap();
    cpu_req = 1'b1; cpu_we = 1'b0; vga_rdn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vga_addr = 19'h10 + 19'(i);
      cycle();
    end
    chk("vga_block_ack", 32'(n_ack - ak0), 32'd0);
    vga_rdn = 1'b1;
    cycle();
    cpu_req = 1'b0;
    cycle();
    chk("vga_then_ack", 32'(n_ack - ak0), 32'd1);
    chk("vga_valid_cnt", 32'(n_vv - vv0), 32'd5);

    // wrapping fill
    snap();
    fill_start = 1'b1; fill_base = 19'h7FFFE;
    fill_len = 19'd4; fill_color = 12'hF00;
    cycle();
    fill_start = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    chk("wrap_nwr", 32'(wq.size()), 32'd4);
    if (wq.size() == 4) begin
      chk("wrap_a0", 32'(wq[0]), 32'h7FFFE);
      chk("wrap_a1", 32'(wq[1]), 32'h7FFFF);
      chk("wrap_a2", 32'(wq[2]), 32'h00000);
      chk("wrap_a3", 32'(wq[3]), 32'h00001);
    end
    chk("wrap_done", 32'(n_done - dn0), 32'd1);

    // fill of 8 against continuous CPU reads, from fresh rr state
    rst = 1'b1; cycle(); rst = 1'b0;
    snap();
    fill_start = 1'b1; fill_base = 19'h100; fill_len = 19'd8;
    fill_color = 12'h05A;
    cycle();
    fill_start = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cpu_addr = 19'($urandom_range(0, 31));
      cycle();
    end
    cpu_req = 1'b0;
    cycle(); cycle();
    chk("rr_busy_cycles", 32'(n_busy - bz0), 32'd16);
    chk("rr_fill_writes", 32'(n_we - we0), 32'd8);
    chk("rr_done", 32'(n_done - dn0), 32'd1);

    // zero-length fill
    snap();
    fill_start = 1'b1; fill_len = '0;
    cycle();
    fill_start = 1'b0;
    cycle(); cycle();
    chk("len0_done", 32'(n_done - dn0), 32'd1);
    chk("len0_writes", 32'(n_we - we0), 32'd0);
    chk("len0_busy", 32'(n_busy - bz0), 32'd0);

    // reset on the third fill write
    snap();
    fill_start = 1'b1; fill_base = 19'h200; fill_len = 19'd8;
    cycle();
    fill_start = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("abort_writes", 32'(n_we - we0), 32'd2);
    chk("abort_done", 32'(n_done - dn0), 32'd0);
    chk("abort_busy", 32'(fill_busy), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 399) == 0);
      vga_rdn    = ($urandom_range(0, 3) != 0);
      vga_addr   = 19'($urandom_range(0, 47));
      cpu_req    = ($urandom_range(0, 1) == 1);
      cpu_we     = ($urandom_range(0, 1) == 1);
      cpu_addr   = 19'($urandom_range(0, 47));
      cpu_wdata  = 12'($urandom);
      fill_start = ($urandom_range(0, 15) == 0);
      fill_base  = ($urandom_range(0, 3) == 0) ? 19'h7FFFA
                                               : 19'($urandom_range(0, 40));
      fill_len   = 19'($urandom_range(0, 12));
      fill_color = 12'($urandom);
      cycle();
    end
    rst = 1'b0;
    idle_in();
    for (int i = 0; i < 20; i++) cycle();
    chk("end_busy", 32'(fill_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
